fetch_redirect_ctrl: RTL and testbench
======================================

Name: fetch_redirect_ctrl

Overview:
Front-end counterpart of the write-back flush interface. It consumes the WB-stage exception, ERET, TLB-refill and refetch flush indications and turns them into a held PC redirect request for the pre-IF stage. It tracks in-flight instruction-bus requests so that responses belonging to the flushed path are marked for discard. It sits between the WB flush outputs and pre-IF/IF, and observes the inst-SRAM-like handshake.

Parameters:
EXC_VEC, 32'hbfc00380, general exception entry vector
REFILL_VEC, 32'hbfc00200, TLB refill exception entry vector
MAX_OUTST, 3, maximum in-flight instruction requests; counter width = $clog2(MAX_OUTST+1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
ws_exc  in  1  valid exception flush from WB
ws_refill  in  1  exception is a TLB refill (qualified by ws_exc)
ws_eret  in  1  valid ERET flush from WB
ws_refetch  in  1  valid TLB-write refetch flush from WB
ws_epc  in  32  CP0 EPC, ERET target
ws_refetch_pc  in  32  refetch target (PC of instruction after the TLB op)
fs_req  in  1  pre-IF instruction request
fs_addr_ok  in  1  inst bus accepted the request
fs_data_ok  in  1  inst bus returned data
redirect_valid  out  1  redirect pending; pre-IF must fetch redirect_pc
redirect_pc  out  32  redirect target
data_cancel  out  1  current fs_data_ok belongs to the flushed path; IF drops it
outstanding  out  W  in-flight request count (debug and verification)

Behaviour:
- flush_evt = ws_exc | ws_eret | ws_refetch. acc = fs_req & fs_addr_ok. dok = fs_data_ok.
- Target priority: ws_exc&ws_refill -> REFILL_VEC; ws_exc -> EXC_VEC; ws_eret -> ws_epc; ws_refetch -> ws_refetch_pc.
- outstanding: next = outstanding + acc - dok, updated every cycle, wraps are illegal. The bus never exceeds MAX_OUTST and no dok arrives at 0. Both are bench assertions only; there is no RTL check.
- FSM has two states, IDLE and REDIRECT.
  - IDLE & flush_evt: latch the target into redirect_pc and go to REDIRECT. redirect_valid=1 from the next cycle (1-cycle latency).
  - REDIRECT & flush_evt: relatch the target (latest wins) and stay in REDIRECT. The flush has priority over consumption in the same cycle.
  - REDIRECT & acc & !flush_evt: the redirect is consumed and the FSM goes to IDLE. redirect_valid=0 next cycle. That request is new-path and is not cancelled.
  - Pre-IF issues only redirect_pc while redirect_valid=1, so any acc in REDIRECT is the redirect fetch.
- cancel_cnt (W bits, internal):
  - On flush_evt: cancel_cnt <= outstanding + acc - dok. A request accepted in the flush cycle is old-path. A dok in the flush cycle is already flushed by the pipeline and is not counted.
  - Otherwise, on dok with cancel_cnt != 0: decrement.
- data_cancel = dok & (cancel_cnt != 0). It is combinational from the registered count, and it is 0 in the flush cycle itself.
- Cancelled responses always precede new-path responses (the bus is in-order). cancel_cnt reaching 0 marks the first new-path response.
- Reset values: FSM=IDLE, redirect_valid=0, redirect_pc=32'h0, outstanding=0, cancel_cnt=0, data_cancel=0.
- Reset mid-REDIRECT or mid-cancel: everything clears next cycle. The bus is reset concurrently.
- Simultaneous flush sources are legal; priority applies.
- A flush while cancel_cnt != 0 recomputes cancel_cnt from outstanding, which already includes the remaining old requests.

Test Plan:
1. Idle, outstanding=0; ws_exc=1 at cycle 0 -> cycle 1 redirect_valid=1, redirect_pc=32'hbfc00380; acc at cycle 3 -> cycle 4 redirect_valid=0; data_cancel never asserts.
2. ws_exc=1, ws_refill=1, ws_eret=1 same cycle -> redirect_pc=32'hbfc00200.
3. outstanding=2; ws_eret=1, ws_epc=32'h80001234 -> redirect_pc=32'h80001234; next two dok have data_cancel=1; the redirect fetch's dok has data_cancel=0; outstanding returns to 0.
4. outstanding=1; flush with acc=1 and dok=1 in the same cycle -> cancel_cnt=1; exactly one later dok cancelled.
5. ws_refetch (pc 32'h80000010), then ws_exc two cycles later while in REDIRECT with acc=1 that cycle -> stays in REDIRECT, redirect_pc=32'hbfc00380, and the acc'd request is cancelled.
6. reset asserted in REDIRECT with cancel_cnt=2 -> next cycle redirect_valid=0, outstanding=0, data_cancel=0 on subsequent dok.

Source files
------------

// File: rtl/fetch_redirect_ctrl.sv
// rtl/fetch_redirect_ctrl.sv - WB flush to pre-IF redirect request with stale-response cancel tracking
module fetch_redirect_ctrl #(
  parameter logic [31:0] EXC_VEC    = 32'hbfc00380,
  parameter logic [31:0] REFILL_VEC = 32'hbfc00200,
  parameter int          MAX_OUTST  = 3,
  localparam int         W          = $clog2(MAX_OUTST + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         ws_exc,
  input  logic         ws_refill,
  input  logic         ws_eret,
  input  logic         ws_refetch,
  input  logic [31:0]  ws_epc,
  input  logic [31:0]  ws_refetch_pc,
  input  logic         fs_req,
  input  logic         fs_addr_ok,
  input  logic         fs_data_ok,
  output logic         redirect_valid,
  output logic [31:0]  redirect_pc,
  output logic         data_cancel,
  output logic [W-1:0] outstanding
);

  typedef enum logic {IDLE, REDIRECT} state_t;

  state_t        state, state_nxt;
  logic [31:0]   pc_nxt;
  logic [31:0]   flush_target;
  logic [W-1:0]  outst_nxt;
  logic [W-1:0]  cancel_cnt, cancel_nxt;
  logic          flush_evt, acc, dok;

  assign flush_evt = ws_exc | ws_eret | ws_refetch;
  assign acc       = fs_req & fs_addr_ok;
  assign dok       = fs_data_ok;

  always_comb begin
    flush_target = ws_refetch_pc;
    if (ws_exc && ws_refill) flush_target = REFILL_VEC;
    else if (ws_exc)         flush_target = EXC_VEC;
    else if (ws_eret)        flush_target = ws_epc;
  end

  always_comb begin
    state_nxt  = state;
    pc_nxt     = redirect_pc;
    outst_nxt  = outstanding + W'(acc) - W'(dok);
    cancel_nxt = cancel_cnt;
    case (state)
      IDLE: begin
        if (flush_evt) begin
          state_nxt = REDIRECT;
          pc_nxt    = flush_target;
        end
      end
      REDIRECT: begin
        // A flush outranks consumption: the newest target must be fetched.
        if (flush_evt) begin
          pc_nxt = flush_target;
        end else if (acc) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Everything in flight after this cycle (incl. a same-cycle accept) is old-path.
    if (flush_evt) begin
      cancel_nxt = outst_nxt;
    end else if (dok && (cancel_cnt != '0)) begin
      cancel_nxt = cancel_cnt - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      redirect_pc <= 32'h0;
      outstanding <= '0;
      cancel_cnt  <= '0;
    end else begin
      state       <= state_nxt;
      redirect_pc <= pc_nxt;
      outstanding <= outst_nxt;
      cancel_cnt  <= cancel_nxt;
    end
  end

  assign redirect_valid = (state == REDIRECT);
  // A response in the flush cycle is already dropped by the pipeline itself.
  assign data_cancel    = dok & (cancel_cnt != '0) & ~flush_evt;

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb/tb_fetch_redirect_ctrl.sv - directed self-checking bench for fetch_redirect_ctrl
module tb_fetch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        ws_exc, ws_refill, ws_eret, ws_refetch;
  logic [31:0] ws_epc, ws_refetch_pc;
  logic        fs_req, fs_addr_ok, fs_data_ok;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        data_cancel;
  logic [1:0]  outstanding;

  int n_checks = 0;
  int n_fail   = 0;

  fetch_redirect_ctrl dut (
    .clk(clk), .reset(reset),
    .ws_exc(ws_exc), .ws_refill(ws_refill), .ws_eret(ws_eret), .ws_refetch(ws_refetch),
    .ws_epc(ws_epc), .ws_refetch_pc(ws_refetch_pc),
    .fs_req(fs_req), .fs_addr_ok(fs_addr_ok), .fs_data_ok(fs_data_ok),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .data_cancel(data_cancel), .outstanding(outstanding)
  );

  always #5 clk = ~clk;

  task automatic clear_in();
    ws_exc = 0; ws_refill = 0; ws_eret = 0; ws_refetch = 0;
    fs_req = 0; fs_addr_ok = 0; fs_data_ok = 0;
  endtask

  // Ends the current cycle; inputs return to idle 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_in();
    n_checks++;
    if (outstanding > 2'd3) begin n_fail++; $display("FAIL bus_max_outst: got %0d want <=3", outstanding); end
  endtask

  task automatic set_in(input logic exc, refill, eret, refetch, acc, dok);
    ws_exc = exc; ws_refill = refill; ws_eret = eret; ws_refetch = refetch;
    fs_req = acc; fs_addr_ok = acc; fs_data_ok = dok;
    #1;
    if (dok && !reset) begin
      n_checks++;
      if (outstanding == 2'd0) begin n_fail++; $display("FAIL bus_dok_at_zero: got outstanding %0d want >0", outstanding); end
    end
  endtask

  task automatic test_reset();
    reset = 1; clear_in(); ws_epc = 0; ws_refetch_pc = 0;
    tick(); tick();
    fs_data_ok = 1; #1;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL rst_rv: got %b want 0", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL rst_pc: got %h want 00000000", redirect_pc); end
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL rst_outst: got %0d want 0", outstanding); end
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL rst_dc: got %b want 0", data_cancel); end
    tick();
    reset = 0;
  endtask

  task automatic test_exc_basic();
    set_in(1, 0, 0, 0, 0, 0); tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t1_rv_c1: got %b want 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'hbfc00380) begin n_fail++; $display("FAIL t1_pc: got %h want bfc00380", redirect_pc); end
    tick(); tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t1_rv_c3: got %b want 1", redirect_valid); end
    set_in(0, 0, 0, 0, 1, 0); tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t1_rv_c4: got %b want 0", redirect_valid); end
    n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL t1_outst: got %0d want 1", outstanding); end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t1_dc: got %b want 0", data_cancel); end
    tick();
  endtask

  task automatic test_priority();
    ws_epc = 32'h80005555;
    set_in(1, 1, 1, 0, 0, 0); tick();
    n_checks++; if (redirect_pc !== 32'hbfc00200) begin n_fail++; $display("FAIL t2_pc: got %h want bfc00200", redirect_pc); end
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t2_rv: got %b want 1", redirect_valid); end
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t2_dc: got %b want 0", data_cancel); end
    tick();
  endtask

  task automatic test_eret_cancel();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    n_checks++; if (outstanding !== 2'd2) begin n_fail++; $display("FAIL t3_outst2: got %0d want 2", outstanding); end
    ws_epc = 32'h80001234;
    set_in(0, 0, 1, 0, 0, 0); tick();
    n_checks++; if (redirect_pc !== 32'h80001234) begin n_fail++; $display("FAIL t3_pc: got %h want 80001234", redirect_pc); end
    for (int i = 0; i < 2; i++) begin
      set_in(0, 0, 0, 0, 0, 1);
      n_checks++; if (data_cancel !== 1'b1) begin n_fail++; $display("FAIL t3_dc_old%0d: got %b want 1", i, data_cancel); end
      tick();
    end
    set_in(0, 0, 0, 0, 1, 0); tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t3_rv: got %b want 0", redirect_valid); end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t3_dc_new: got %b want 0", data_cancel); end
    tick();
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL t3_outst0: got %0d want 0", outstanding); end
  endtask

  task automatic test_flush_acc_dok();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(1, 0, 0, 0, 1, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t4_dc_flush: got %b want 0", data_cancel); end
    tick();
    n_checks++; if (outstanding !== 2'd1) begin n_fail++; $display("FAIL t4_outst: got %0d want 1", outstanding); end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b1) begin n_fail++; $display("FAIL t4_dc_old: got %b want 1", data_cancel); end
    tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t4_dc_new: got %b want 0", data_cancel); end
    tick();
  endtask

  task automatic test_back_to_back();
    ws_refetch_pc = 32'h80000010;
    set_in(0, 0, 0, 1, 0, 0); tick();
    n_checks++; if (redirect_pc !== 32'h80000010) begin n_fail++; $display("FAIL t5_pc1: got %h want 80000010", redirect_pc); end
    tick();
    set_in(1, 0, 0, 0, 1, 0); tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t5_rv: got %b want 1", redirect_valid); end
    n_checks++; if (redirect_pc !== 32'hbfc00380) begin n_fail++; $display("FAIL t5_pc2: got %h want bfc00380", redirect_pc); end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b1) begin n_fail++; $display("FAIL t5_dc_old: got %b want 1", data_cancel); end
    tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t5_rv_end: got %b want 0", redirect_valid); end
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t5_dc_new: got %b want 0", data_cancel); end
    tick();
  endtask

  task automatic test_reset_mid_cancel();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(1, 0, 0, 0, 0, 0); tick();
    n_checks++; if (redirect_valid !== 1'b1) begin n_fail++; $display("FAIL t6_rv_pre: got %b want 1", redirect_valid); end
    reset = 1; tick(); reset = 0;
    n_checks++; if (redirect_valid !== 1'b0) begin n_fail++; $display("FAIL t6_rv: got %b want 0", redirect_valid); end
    n_checks++; if (outstanding !== 2'd0) begin n_fail++; $display("FAIL t6_outst: got %0d want 0", outstanding); end
    n_checks++; if (redirect_pc !== 32'h0) begin n_fail++; $display("FAIL t6_pc: got %h want 00000000", redirect_pc); end
    set_in(0, 0, 0, 0, 1, 0); tick();
    set_in(0, 0, 0, 0, 0, 1);
    n_checks++; if (data_cancel !== 1'b0) begin n_fail++; $display("FAIL t6_dc: got %b want 0", data_cancel); end
    tick();
  endtask

  initial begin
    test_reset();
    test_exc_basic();
    test_priority();
    test_eret_cancel();
    test_flush_acc_dok();
    test_back_to_back();
    test_reset_mid_cancel();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
